// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Pipeline stage register with valid/ready handshake. It holds a main entry
//   that drives the outputs and one skid entry that catches a beat which
//   arrives while the main entry is stalled. A synchronous flush turns the
//   stage into a bubble. After reset, in_ready is held low for a warm-up
//   period. The control field is forced to CTRL_BUBBLE whenever no valid
//   instruction is presented, so a stalled or empty stage can never issue a
//   write downstream.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset_n    : asynchronous active-low reset
//   flush      : synchronous kill of main and skid entries
//   in_valid   : upstream offers in_data/in_ctrl
//   in_ready   : stage accepts this cycle (warm, skid free, no flush)
//   in_data    : upstream datapath payload
//   in_ctrl    : upstream control payload
//   out_valid  : out_data/out_ctrl carry a live instruction
//   out_ready  : downstream accepts (0 = stall)
//   out_data   : registered datapath payload (holds its value when empty)
//   out_ctrl   : registered control payload, CTRL_BUBBLE when out_valid=0
//   occupancy  : live entries held (0, 1 or 2)
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int unsigned        DATA_W      = 16,
    parameter int unsigned        CTRL_W      = 12,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
    parameter int unsigned        WARMUP      = 1     // 0..15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    localparam logic [3:0] WARMUP_CNT = WARMUP[3:0];

    // Main entry (drives the outputs) and skid entry (catches a beat during a stall).
    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

    // Warm-up: edges since reset release, saturating at WARMUP. warm_q is
    // registered so that WARMUP=0 still keeps in_ready low until the first edge.
    logic [3:0] warm_cnt_q, warm_cnt_d;
    logic       warm_q,     warm_d;

    logic in_fire;
    logic out_fire;

    // in_ready depends only on local state and flush; out_ready never reaches it.
    assign in_ready  = warm_q & ~skid_valid_q & ~flush;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = main_valid_q;
    assign out_fire  = main_valid_q & out_ready;
    assign out_data  = main_data_q;
    // Mask stale control bits so that an empty stage always looks like a no-op.
    assign out_ctrl  = main_valid_q ? main_ctrl_q : CTRL_BUBBLE;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        warm_cnt_d   = (warm_cnt_q == WARMUP_CNT) ? warm_cnt_q : warm_cnt_q + 4'd1;
        warm_d       = (warm_cnt_d == WARMUP_CNT);

        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;

        if (flush) begin
            // Kill both entries; payload registers keep their last value.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_fire) begin
            // Main slot frees up this edge: the skid is older than any new offer.
            // in_ready is low while the skid is full, so both cannot fire together.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_ctrl_d  = skid_ctrl_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
                main_ctrl_d  = in_ctrl;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            // Main is stalled: park the new beat in the skid.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    // NOTE: the payload registers are reset as well because out_data must read
    // 0 out of reset; the skid payload follows for symmetry and X-free outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt_q   <= '0;
            warm_q       <= 1'b0;
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= CTRL_BUBBLE;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= CTRL_BUBBLE;
        end else begin
            warm_cnt_q   <= warm_cnt_d;
            warm_q       <= warm_d;
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end

endmodule
